// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response codes, burst encodings and slave FSM states
package axi_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_EXOKAY = 3'b001;
  localparam logic [2:0] RESP_SLVERR = 3'b010;
  localparam logic [2:0] RESP_DECERR = 3'b011;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WR_DATA = 2'b01,
    ST_WR_RESP = 2'b10,
    ST_RD_DATA = 2'b11
  } slv_state_e;

endpackage

// File: rtl/axi_slv_sram.sv
// rtl/axi_slv_sram.sv - single-port synchronous SRAM with per-byte write enables
module axi_slv_sram #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk_i,
  input  logic                         en_i,
  input  logic                         we_i,
  input  logic [DATA_W/8-1:0]          be_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data register only updates on a read, so it holds across stalls.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 slave fronting an SRAM, one transaction at a time.
// Define AXI_SLV_STRB_EN to honour s_wstrb per byte; otherwise every beat writes the full word.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int               ID_W      = 4,
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               LEN_W     = 8,
  parameter int               SIZE_W    = 3,
  parameter int               MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [LEN_W-1:0]    s_awlen,
  input  logic [SIZE_W-1:0]   s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [2:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [LEN_W-1:0]    s_arlen,
  input  logic [SIZE_W-1:0]   s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [2:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int NB        = DATA_W / 8;
  localparam int SIZE_LOG2 = $clog2(NB);
  localparam int AW        = $clog2(MEM_DEPTH);

  slv_state_e          state_q, state_d;
  logic                ready_q, prio_wr_q;
  logic [ID_W-1:0]     id_q;
  logic [AW-1:0]       addr_q;
  logic [LEN_W-1:0]    len_q, beat_q;
  logic                incr_q;
  logic [2:0]          resp_q;

  logic                aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic [ID_W-1:0]     ax_id;
  logic [ADDR_W-1:0]   ax_addr;
  logic [LEN_W-1:0]    ax_len;
  logic [SIZE_W-1:0]   ax_size;
  logic [1:0]          ax_burst;
  logic                ax_incr, ax_err;
  logic [ADDR_W:0]     off, last_word;
  logic [AW-1:0]       start_idx;
  logic                wlast_ok, mem_we, sram_en;
  logic [AW-1:0]       sram_addr;
  logic [NB-1:0]       sram_be;
  logic [DATA_W-1:0]   sram_rdata;
  logic                unused_lo;

  // Both readies share one registered enable; the priority flag breaks ties.
  assign s_awready = ready_q & (~s_arvalid | prio_wr_q);
  assign s_arready = ready_q & (~s_awvalid | ~prio_wr_q);
  assign aw_hs = s_awvalid & s_awready;
  assign ar_hs = s_arvalid & s_arready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;
  assign r_hs  = s_rvalid & s_rready;

  assign ax_id    = aw_hs ? s_awid    : s_arid;
  assign ax_addr  = aw_hs ? s_awaddr  : s_araddr;
  assign ax_len   = aw_hs ? s_awlen   : s_arlen;
  assign ax_size  = aw_hs ? s_awsize  : s_arsize;
  assign ax_burst = aw_hs ? s_awburst : s_arburst;
  assign ax_incr  = (ax_burst == BURST_INCR);

  // The borrow out of the subtraction flags addresses below BASE_ADDR.
  assign off       = {1'b0, ax_addr} - {1'b0, BASE_ADDR};
  assign start_idx = off[AW+SIZE_LOG2-1:SIZE_LOG2];
  assign last_word = (ADDR_W+1)'(off[ADDR_W-1:SIZE_LOG2]) +
                     (ax_incr ? (ADDR_W+1)'(ax_len) : '0);
  assign unused_lo = ^off[SIZE_LOG2-1:0];
  assign ax_err    = off[ADDR_W] | (ax_size != SIZE_W'(SIZE_LOG2)) |
                     (ax_burst == BURST_WRAP) | (ax_burst == 2'b11) |
                     (last_word >= (ADDR_W+1)'(MEM_DEPTH));

  // A beat whose wlast disagrees with the beat count is never written.
  assign wlast_ok  = (s_wlast == (beat_q == len_q));
  assign mem_we    = w_hs & wlast_ok & (resp_q == RESP_OKAY);
  assign sram_en   = mem_we | ar_hs | (r_hs & ~s_rlast);
  assign sram_addr = (state_q == ST_IDLE) ? start_idx : addr_q;

`ifdef AXI_SLV_STRB_EN
  assign sram_be = s_wstrb;
`else
  logic unused_strb;
  assign unused_strb = ^s_wstrb;
  assign sram_be     = '1;
`endif

  axi_slv_sram #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en),
    .we_i    (mem_we),
    .be_i    (sram_be),
    .addr_i  (sram_addr),
    .wdata_i (s_wdata),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (aw_hs) state_d = ST_WR_DATA;
                  else if (ar_hs) state_d = ST_RD_DATA;
      ST_WR_DATA: if (w_hs && s_wlast) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
      ST_RD_DATA: if (r_hs && s_rlast) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_wready = (state_q == ST_WR_DATA);
    s_bvalid = (state_q == ST_WR_RESP);
    s_rvalid = (state_q == ST_RD_DATA);
    s_rlast  = s_rvalid && (beat_q == len_q);
    s_rdata  = (s_rvalid && resp_q == RESP_OKAY) ? sram_rdata : '0;
    s_bid    = id_q;
    s_rid    = id_q;
    s_bresp  = resp_q;
    s_rresp  = resp_q;
  end

  // For reads addr_q points at the word to prefetch next; for writes at the current word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q   <= 1'b0;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      incr_q    <= 1'b0;
      resp_q    <= RESP_OKAY;
    end else begin
      ready_q <= (state_d == ST_IDLE);
      if (aw_hs || ar_hs) begin
        prio_wr_q <= ~prio_wr_q;
        id_q      <= ax_id;
        len_q     <= ax_len;
        incr_q    <= ax_incr;
        beat_q    <= '0;
        resp_q    <= ax_err ? RESP_SLVERR : RESP_OKAY;
        addr_q    <= (ar_hs && ax_incr) ? start_idx + 1'b1 : start_idx;
      end
      if (w_hs) begin
        beat_q <= beat_q + 1'b1;
        if (incr_q) addr_q <= addr_q + 1'b1;
        if (!wlast_ok) resp_q <= RESP_SLVERR;
      end
      if (r_hs) begin
        beat_q <= beat_q + 1'b1;
        if (incr_q) addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_awid, s_arid, s_bid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize, s_bresp, s_rresp;
  logic [1:0]  s_awburst, s_arburst;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rlast, s_rvalid, s_rready;

  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] wr_data [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [2:0]  rd_resp, b_resp;
  logic [3:0]  rd_id, b_id;
  int          rd_got, rd_stall_bad, rd_span, rd_first;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic timeout(input string what);
    n_cmp++; n_err++;
    $display("FAIL timeout_%s: handshake not seen, required within 200 cycles", what);
  endtask

  task automatic aw_send(input [3:0] id, input [31:0] a, input [7:0] len,
                         input [2:0] size, input [1:0] burst);
    int n = 0;
    s_awid = id; s_awaddr = a; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    @(negedge clk);
    while (!s_awready && n < 200) begin @(negedge clk); n++; end
    if (!s_awready) timeout("aw");
    @(posedge clk); #1 s_awvalid = 1'b0;
  endtask

  task automatic ar_send(input [3:0] id, input [31:0] a, input [7:0] len,
                         input [2:0] size, input [1:0] burst);
    int n = 0;
    s_arid = id; s_araddr = a; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < 200) begin @(negedge clk); n++; end
    if (!s_arready) timeout("ar");
    @(posedge clk); #1 s_arvalid = 1'b0;
  endtask

  task automatic w_send(input [31:0] d, input [3:0] strb, input last);
    int n = 0;
    s_wdata = d; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
    @(negedge clk);
    while (!s_wready && n < 200) begin @(negedge clk); n++; end
    if (!s_wready) timeout("w");
    @(posedge clk); #1 s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic b_recv();
    int n = 0;
    s_bready = 1'b1;
    @(negedge clk);
    while (!s_bvalid && n < 200) begin @(negedge clk); n++; end
    if (!s_bvalid) timeout("b");
    b_id = s_bid; b_resp = s_bresp;
    @(posedge clk); #1 s_bready = 1'b0;
  endtask

  task automatic r_recv(input int nbeats, input logic [15:0] pat);
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    rd_got = 0; rd_stall_bad = 0; rd_span = -1; rd_first = -1;
    while (rd_got < nbeats && cyc < 200) begin
      s_rready = pat[cyc % 16];
      @(negedge clk);
      if (prev_stall && (s_rdata !== pd || s_rlast !== pl || !s_rvalid)) rd_stall_bad++;
      prev_stall = s_rvalid && !s_rready;
      pd = s_rdata; pl = s_rlast;
      if (s_rvalid && s_rready) begin
        rd_data[rd_got] = s_rdata; rd_last[rd_got] = s_rlast;
        rd_resp = s_rresp; rd_id = s_rid;
        if (rd_got == 0) rd_first = cyc;
        if (rd_got == nbeats - 1) rd_span = cyc - rd_first;
        rd_got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_rready = 1'b0;
    if (rd_got < nbeats) timeout("r");
  endtask

  task automatic wr_txn(input [3:0] id, input [31:0] a, input [7:0] len, input [2:0] size,
                        input [1:0] burst, input [3:0] strb, input int nbeats);
    aw_send(id, a, len, size, burst);
    for (int i = 0; i < nbeats; i++) w_send(wr_data[i], strb, i == nbeats - 1);
    b_recv();
  endtask

  task automatic rd_txn(input [3:0] id, input [31:0] a, input [7:0] len, input [2:0] size,
                        input [1:0] burst, input logic [15:0] pat);
    ar_send(id, a, len, size, burst);
    r_recv(int'(len) + 1, pat);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    apply_reset();
    got = {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast,
           s_bresp, s_rresp};
    n_cmp++;
    if (got !== 12'h000) begin
      n_err++; $display("FAIL reset_ctrl: got %h, required 000", got);
    end
    n_cmp++;
    if ({s_bid, s_rid, s_rdata} !== 40'h0) begin
      n_err++; $display("FAIL reset_data: bid %h rid %h rdata %h, required 0", s_bid, s_rid, s_rdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    wr_data[0] = 32'hDEADBEEF;
    wr_txn(4'h5, 32'h10, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    n_cmp++;
    if (b_resp !== 3'b000 || b_id !== 4'h5) begin
      n_err++; $display("FAIL single_b: resp %h id %h, required 0 5", b_resp, b_id);
    end
    rd_txn(4'h9, 32'h10, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_resp !== 3'b000 || rd_id !== 4'h9) begin
      n_err++; $display("FAIL single_r: data %h last %b resp %h id %h, required deadbeef 1 0 9",
                        rd_data[0], rd_last[0], rd_resp, rd_id);
    end
    n_cmp++;
    if (rd_first !== 0) begin
      n_err++; $display("FAIL single_latency: first beat at cycle %0d, required 0", rd_first);
    end
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
    wr_txn(4'h3, 32'h40, 8'd3, 3'd2, 2'b01, 4'hF, 4);
    n_cmp++;
    if (b_resp !== 3'b000 || b_id !== 4'h3) begin
      n_err++; $display("FAIL incr_b: resp %h id %h, required 0 3", b_resp, b_id);
    end
    rd_txn(4'h2, 32'h40, 8'd3, 3'd2, 2'b01, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
        n_err++; $display("FAIL incr_beat%0d: data %h last %b, required %h %b",
                          i, rd_data[i], rd_last[i], i + 1, i == 3);
      end
    end
    n_cmp++;
    if (rd_span !== 3) begin
      n_err++; $display("FAIL incr_stream: 4 beats took span %0d, required 3", rd_span);
    end
  endtask

  task automatic test_fixed();
    wr_data[0] = 32'h0000_000A; wr_data[1] = 32'h0000_000B;
    wr_txn(4'h1, 32'h80, 8'd1, 3'd2, 2'b00, 4'hF, 2);
    rd_txn(4'h1, 32'h80, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_data[0] !== 32'h0000_000B || b_resp !== 3'b000) begin
      n_err++; $display("FAIL fixed: data %h bresp %h, required 0000000b 0", rd_data[0], b_resp);
    end
  endtask

  task automatic test_backpressure();
    rd_txn(4'h6, 32'h40, 8'd3, 3'd2, 2'b01, 16'hFFF9);
    n_cmp++;
    if (rd_got !== 4 || rd_stall_bad !== 0) begin
      n_err++; $display("FAIL bp_stable: beats %0d unstable %0d, required 4 0", rd_got, rd_stall_bad);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
        n_err++; $display("FAIL bp_beat%0d: data %h last %b, required %h %b",
                          i, rd_data[i], rd_last[i], i + 1, i == 3);
      end
    end
  endtask

  task automatic test_errors();
    wr_data[0] = 32'hCAFE0000;
    wr_txn(4'h1, 32'h0, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    wr_data[0] = 32'h12345678;
    wr_txn(4'h2, 32'h1000, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    n_cmp++;
    if (b_resp !== 3'b010) begin
      n_err++; $display("FAIL err_range_w: bresp %h, required 2", b_resp);
    end
    rd_txn(4'h3, 32'h0, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_data[0] !== 32'hCAFE0000 || rd_resp !== 3'b000) begin
      n_err++; $display("FAIL err_mem_kept: data %h resp %h, required cafe0000 0", rd_data[0], rd_resp);
    end
    rd_txn(4'h4, 32'h1000, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_data[0] !== 32'h0 || rd_resp !== 3'b010) begin
      n_err++; $display("FAIL err_range_r: data %h resp %h, required 0 2", rd_data[0], rd_resp);
    end
    wr_txn(4'h5, 32'h20, 8'd0, 3'd1, 2'b01, 4'hF, 1);
    n_cmp++;
    if (b_resp !== 3'b010) begin
      n_err++; $display("FAIL err_size: bresp %h, required 2", b_resp);
    end
    wr_txn(4'h6, 32'h24, 8'd1, 3'd2, 2'b10, 4'hF, 2);
    n_cmp++;
    if (b_resp !== 3'b010) begin
      n_err++; $display("FAIL err_wrap: bresp %h, required 2", b_resp);
    end
    rd_txn(4'h7, 32'hFFC, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_resp !== 3'b000) begin
      n_err++; $display("FAIL err_last_word: rresp %h, required 0", rd_resp);
    end
    rd_txn(4'h7, 32'hFFC, 8'd1, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_resp !== 3'b010 || rd_data[0] !== 32'h0) begin
      n_err++; $display("FAIL err_cross_end: rresp %h data %h, required 2 0", rd_resp, rd_data[0]);
    end
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h5555_0000 + 32'(i);
    wr_txn(4'h7, 32'h60, 8'd3, 3'd2, 2'b01, 4'hF, 2);
    n_cmp++;
    if (b_resp !== 3'b010 || b_id !== 4'h7) begin
      n_err++; $display("FAIL err_early_wlast: bresp %h bid %h, required 2 7", b_resp, b_id);
    end
    rd_txn(4'h8, 32'h10, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_resp !== 3'b000 || rd_id !== 4'h8) begin
      n_err++; $display("FAIL err_recover: data %h resp %h id %h, required deadbeef 0 8",
                        rd_data[0], rd_resp, rd_id);
    end
  endtask

  task automatic test_strb();
    logic [31:0] exp;
`ifdef AXI_SLV_STRB_EN
    exp = 32'h11BB11DD;
`else
    exp = 32'hAABBCCDD;
`endif
    wr_data[0] = 32'h11111111;
    wr_txn(4'h1, 32'h30, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    wr_data[0] = 32'hAABBCCDD;
    wr_txn(4'h1, 32'h30, 8'd0, 3'd2, 2'b01, 4'b0101, 1);
    rd_txn(4'h1, 32'h30, 8'd0, 3'd2, 2'b01, 16'hFFFF);
    n_cmp++;
    if (rd_data[0] !== exp) begin
      n_err++; $display("FAIL strb: data %h, required %h", rd_data[0], exp);
    end
  endtask

  task automatic test_arbitration();
    int  n;
    logic got_w, both;
    test_reset();
    for (int r = 0; r < 4; r++) begin
      s_awid = 4'(r); s_awaddr = 32'h200 + 32'(r * 4); s_awlen = 0; s_awsize = 3'd2; s_awburst = 2'b01;
      s_arid = 4'(r); s_araddr = 32'h10; s_arlen = 0; s_arsize = 3'd2; s_arburst = 2'b01;
      s_awvalid = 1'b1; s_arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(s_awready || s_arready) && n < 200) begin @(negedge clk); n++; end
      got_w = s_awready; both = s_awready && s_arready;
      if (!(s_awready || s_arready)) timeout("arb");
      @(posedge clk); #1 s_awvalid = 1'b0; s_arvalid = 1'b0;
      n_cmp++;
      if (got_w !== (r % 2 == 0) || both !== 1'b0) begin
        n_err++; $display("FAIL arb_round%0d: write_won %b both %b, required %b 0",
                          r, got_w, both, r % 2 == 0);
      end
      if (got_w) begin
        w_send(32'(r), 4'hF, 1'b1);
        b_recv();
      end else begin
        r_recv(1, 16'hFFFF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_fixed();
    test_backpressure();
    test_errors();
    test_strb();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
